// File: rtl/select_logic_if.sv
// Bundle of scheduler-side signals between wakeup/allocation and the select stage.
// master drives allocation, requests and FU readiness; slave returns grants and issues.
interface select_logic_if #(
  parameter int NUM_ROWS = 8,
  parameter int NUM_FUS  = 4,
  parameter int LAT_W    = 8
);
  localparam int RW = $clog2(NUM_ROWS);
  localparam int FW = $clog2(NUM_FUS);

  logic                    flush;
  logic                    alloc_en;
  logic [RW-1:0]           alloc_row;
  logic [FW-1:0]           alloc_fu;
  logic [LAT_W-1:0]        alloc_occ;
  logic [NUM_ROWS-1:0]     request_vector;
  logic [NUM_FUS-1:0]      fu_ready;
  logic [NUM_ROWS-1:0]     grant_vector;
  logic [NUM_FUS-1:0]      issue_valid;
  logic [NUM_FUS*RW-1:0]   issue_row;

  modport master (
    output flush, alloc_en, alloc_row, alloc_fu, alloc_occ, request_vector, fu_ready,
    input  grant_vector, issue_valid, issue_row
  );

  modport slave (
    input  flush, alloc_en, alloc_row, alloc_fu, alloc_occ, request_vector, fu_ready,
    output grant_vector, issue_valid, issue_row
  );
endinterface

// File: rtl/select_logic.sv
// Issue-scheduler select stage: oldest-first pick per functional unit via an age matrix,
// registered grants back to wakeup, and busy tracking for non-pipelined FUs.
module select_logic #(
  parameter int NUM_ROWS = 8,
  parameter int NUM_FUS  = 4,
  parameter int LAT_W    = 8
) (
  input logic          clk,
  input logic          rst,
  select_logic_if.slave bus
);
  localparam int RW = $clog2(NUM_ROWS);
  localparam int FW = $clog2(NUM_FUS);

  // Issue handshake: op on issue_row slice f transfers to FU f in any cycle issue_valid[f]
  // is high. It is only raised for picks made while fu_ready[f] was high, so it never stalls.

  logic [NUM_ROWS-1:0] valid;
  logic [NUM_ROWS-1:0] age [NUM_ROWS];
  logic [FW-1:0]       fu_of [NUM_ROWS];
  logic [LAT_W-1:0]    occ [NUM_ROWS];
  logic [LAT_W-1:0]    busy [NUM_FUS];

  logic [NUM_ROWS-1:0] eligible;
  logic [NUM_ROWS-1:0] grant_next;
  logic [NUM_ROWS-1:0] valid_post;
  logic [NUM_ROWS-1:0] older_col [NUM_ROWS];
  logic [NUM_ROWS-1:0] cand [NUM_FUS];
  logic [NUM_ROWS-1:0] win [NUM_FUS];
  logic [RW-1:0]       win_idx [NUM_FUS];
  logic [LAT_W-1:0]    win_occ [NUM_FUS];
  logic                alloc_ok;

  always_comb begin
    eligible = bus.request_vector & valid;
    grant_next = '0;
    // older_col[r][c] set when row c is older than row r
    for (int r = 0; r < NUM_ROWS; r++) begin
      older_col[r] = '0;
      for (int c = 0; c < NUM_ROWS; c++) begin
        older_col[r][c] = age[c][r];
      end
    end
    for (int f = 0; f < NUM_FUS; f++) begin
      cand[f]    = '0;
      win[f]     = '0;
      win_idx[f] = '0;
      win_occ[f] = '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        cand[f][r] = eligible[r] && (fu_of[r] == FW'(f));
      end
      for (int r = 0; r < NUM_ROWS; r++) begin
        win[f][r] = bus.fu_ready[f] && (busy[f] == '0) && cand[f][r] &&
                    !(|(cand[f] & older_col[r]));
        if (win[f][r]) begin
          win_idx[f] = RW'(r);
          win_occ[f] = occ[r];
        end
      end
      grant_next = grant_next | win[f];
    end
    valid_post = valid & ~grant_next;
    alloc_ok   = bus.alloc_en && !valid[bus.alloc_row];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid            <= '0;
      bus.grant_vector <= '0;
      bus.issue_valid  <= '0;
      bus.issue_row    <= '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        age[r]   <= '0;
        fu_of[r] <= '0;
        occ[r]   <= '0;
      end
      for (int f = 0; f < NUM_FUS; f++) busy[f] <= '0;
    end else if (bus.flush) begin
      valid            <= '0;
      bus.grant_vector <= '0;
      bus.issue_valid  <= '0;
      bus.issue_row    <= '0;
      for (int r = 0; r < NUM_ROWS; r++) age[r] <= '0;
      for (int f = 0; f < NUM_FUS; f++) busy[f] <= '0;
    end else begin
      bus.grant_vector <= grant_next;
      for (int f = 0; f < NUM_FUS; f++) begin
        bus.issue_valid[f]          <= |win[f];
        bus.issue_row[f*RW +: RW]   <= win_idx[f];
        if ((|win[f]) && (win_occ[f] > LAT_W'(1))) begin
          busy[f] <= win_occ[f] - LAT_W'(1);
        end else if (busy[f] != '0) begin
          busy[f] <= busy[f] - LAT_W'(1);
        end
      end
      valid <= valid_post | (alloc_ok ? (NUM_ROWS'(1) << bus.alloc_row) : '0);
      if (alloc_ok) begin
        // New row is younger than every row still valid after this edge's grants
        age[bus.alloc_row]   <= '0;
        fu_of[bus.alloc_row] <= bus.alloc_fu;
        occ[bus.alloc_row]   <= bus.alloc_occ;
        for (int c = 0; c < NUM_ROWS; c++) begin
          if (c != int'(bus.alloc_row)) age[c][bus.alloc_row] <= valid_post[c];
        end
      end
    end
  end

  alloc_to_valid_row: assert property (@(posedge clk) disable iff (!rst)
    !(bus.alloc_en && valid[bus.alloc_row]));

endmodule

// File: tb/tb_select_logic.sv
// Bench for select_logic: directed scenarios plus random traffic, each cycle compared
// against an allocation-timestamp reference model through an expected-value queue.
module tb_select_logic;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  select_logic_if #(.NUM_ROWS(8), .NUM_FUS(4), .LAT_W(8)) bus ();

  select_logic #(.NUM_ROWS(8), .NUM_FUS(4), .LAT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Age is an allocation timestamp: the smallest stamp among eligible rows wins.
  bit [7:0] m_valid;
  int       m_fu   [8];
  int       m_occ  [8];
  int       m_seq  [8];
  int       m_busy [4];
  int       seq_ctr = 0;

  logic [23:0] exp_q[$];

  task automatic model_eval();
    logic [7:0]  g  = '0;
    logic [3:0]  iv = '0;
    logic [11:0] ir = '0;
    bit   [7:0]  pre_valid;
    int          best;
    if (!rst) begin
      m_valid = '0;
      for (int f = 0; f < 4; f++) m_busy[f] = 0;
    end else if (bus.flush) begin
      m_valid = '0;
      for (int f = 0; f < 4; f++) m_busy[f] = 0;
    end else begin
      pre_valid = m_valid;
      for (int f = 0; f < 4; f++) begin
        best = -1;
        if (bus.fu_ready[f] && m_busy[f] == 0) begin
          for (int r = 0; r < 8; r++) begin
            if (m_valid[r] && bus.request_vector[r] && m_fu[r] == f &&
                (best < 0 || m_seq[r] < m_seq[best])) best = r;
          end
        end
        if (best >= 0) begin
          g[best]       = 1'b1;
          iv[f]         = 1'b1;
          ir[f*3 +: 3]  = best[2:0];
          m_busy[f]     = (m_occ[best] > 1) ? m_occ[best] - 1 : 0;
        end else if (m_busy[f] > 0) begin
          m_busy[f] = m_busy[f] - 1;
        end
      end
      m_valid = m_valid & ~g;
      if (bus.alloc_en && !pre_valid[bus.alloc_row]) begin
        m_valid[bus.alloc_row] = 1'b1;
        m_fu[bus.alloc_row]    = int'(bus.alloc_fu);
        m_occ[bus.alloc_row]   = int'(bus.alloc_occ);
        m_seq[bus.alloc_row]   = seq_ctr;
        seq_ctr++;
      end
    end
    exp_q.push_back({g, iv, ir});
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_in(input bit en, input int row, input int fu, input int occv,
                        input logic [7:0] req, input logic [3:0] rdy, input bit fl);
    bus.alloc_en       = en;
    bus.alloc_row      = 3'(row);
    bus.alloc_fu       = 2'(fu);
    bus.alloc_occ      = 8'(occv);
    bus.request_vector = req;
    bus.fu_ready       = rdy;
    bus.flush          = fl;
  endtask

  // One clock: model consumes current inputs, DUT outputs sampled 1 ns after the edge.
  task automatic step();
    logic [23:0] e;
    model_eval();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("model_grant", 32'(bus.grant_vector), 32'(e[23:16]));
    chk("model_ivalid", 32'(bus.issue_valid), 32'(e[15:12]));
    chk("model_irow", 32'(bus.issue_row), 32'(e[11:0]));
  endtask

  task automatic alloc(input int row, input int fu, input int occv);
    set_in(1'b1, row, fu, occv, 8'h00, 4'hF, 1'b0);
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int free_rows[$];
    bit en;
    int row;
    logic [3:0] rdy;

    set_in(1'b0, 0, 0, 0, 8'hFF, 4'hF, 1'b0);
    rst = 1'b0;

    // T1: reset held, all rows requested
    repeat (3) begin
      step();
      chk("t1_grant", 32'(bus.grant_vector), 32'h0);
      chk("t1_ivalid", 32'(bus.issue_valid), 32'h0);
    end
    rst = 1'b1;

    // T2: oldest-first within one FU
    alloc(5, 0, 0);
    alloc(2, 0, 0);
    alloc(7, 0, 0);
    set_in(1'b0, 0, 0, 0, 8'hA4, 4'hF, 1'b0);
    step();
    chk("t2_g0", 32'(bus.grant_vector), 32'h20);
    chk("t2_r0", 32'(bus.issue_row[2:0]), 32'd5);
    step();
    chk("t2_g1", 32'(bus.grant_vector), 32'h04);
    chk("t2_r1", 32'(bus.issue_row[2:0]), 32'd2);
    step();
    chk("t2_g2", 32'(bus.grant_vector), 32'h80);
    chk("t2_r2", 32'(bus.issue_row[2:0]), 32'd7);
    step();
    chk("t2_no_regrant", 32'(bus.grant_vector), 32'h00);

    // T3: one grant on every FU in the same cycle
    for (int i = 0; i < 4; i++) alloc(i, i, 1);
    set_in(1'b0, 0, 0, 0, 8'h0F, 4'hF, 1'b0);
    step();
    chk("t3_ivalid", 32'(bus.issue_valid), 32'hF);
    chk("t3_grant", 32'(bus.grant_vector), 32'h0F);
    chk("t3_irow", 32'(bus.issue_row), 32'h688);
    step();
    chk("t3_held_one_cycle", 32'(bus.grant_vector), 32'h00);

    // T4: occupancy 3 blocks FU2 for the two following select cycles
    alloc(1, 2, 3);
    alloc(4, 2, 0);
    set_in(1'b0, 0, 0, 0, 8'h12, 4'hF, 1'b0);
    step();
    chk("t4_first", 32'(bus.grant_vector), 32'h02);
    step();
    chk("t4_busy_a", 32'(bus.grant_vector), 32'h00);
    step();
    chk("t4_busy_b", 32'(bus.grant_vector), 32'h00);
    step();
    chk("t4_second", 32'(bus.grant_vector), 32'h10);
    chk("t4_second_row", 32'(bus.issue_row[8:6]), 32'd4);

    // T5: backpressure on FU0
    alloc(3, 0, 0);
    set_in(1'b0, 0, 0, 0, 8'h08, 4'hE, 1'b0);
    repeat (4) begin
      step();
      chk("t5_blocked", 32'(bus.grant_vector), 32'h00);
    end
    set_in(1'b0, 0, 0, 0, 8'h08, 4'hF, 1'b0);
    step();
    chk("t5_release", 32'(bus.grant_vector), 32'h08);

    // T6: flush kills pending requesting rows
    for (int i = 0; i < 6; i++) alloc(i, i % 4, 0);
    set_in(1'b0, 0, 0, 0, 8'hFF, 4'hF, 1'b1);
    step();
    chk("t6_flush", 32'(bus.grant_vector), 32'h00);
    set_in(1'b0, 0, 0, 0, 8'hFF, 4'hF, 1'b0);
    repeat (3) begin
      step();
      chk("t6_after_flush", 32'(bus.grant_vector), 32'h00);
    end

    // Reset clears FU busy state
    alloc(1, 2, 3);
    set_in(1'b0, 0, 0, 0, 8'h02, 4'hF, 1'b0);
    step();
    chk("rst_busy_issue", 32'(bus.grant_vector), 32'h02);
    rst = 1'b0;
    set_in(1'b0, 0, 0, 0, 8'h00, 4'hF, 1'b0);
    step();
    chk("rst_busy_reset", 32'(bus.issue_valid), 32'h0);
    rst = 1'b1;
    alloc(0, 2, 0);
    set_in(1'b0, 0, 0, 0, 8'h01, 4'hF, 1'b0);
    step();
    chk("rst_busy_cleared", 32'(bus.grant_vector), 32'h01);

    // Random traffic against the model
    for (int k = 0; k < 500; k++) begin
      free_rows.delete();
      for (int r = 0; r < 8; r++) if (!m_valid[r]) free_rows.push_back(r);
      en  = ($urandom_range(0, 1) == 1) && (free_rows.size() > 0);
      row = en ? free_rows[$urandom_range(0, free_rows.size() - 1)] : 0;
      rdy = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      set_in(en, row, $urandom_range(0, 3), $urandom_range(0, 4),
             8'($urandom_range(0, 255)), rdy, $urandom_range(0, 39) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
